branch_resolver: RTL

- Execute-stage partner of the 2-bit branch predictor. Fetch pushes each predicted branch (predictor state, PC, predicted target) into an in-order in-flight queue.
- When EX resolves the branch, the oldest entry is popped and compared with the actual outcome.
- Produces the history update that feeds the predictor FSM.
- On a wrong prediction: raises a mispredict pulse and redirect PC, and runs a flush state machine that discards wrong-path queue entries.

---
 rtl/branch_resolver.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/branch_resolver.sv
// branch_resolver: execute-stage companion to the 2-bit branch predictor.
// Fetch pushes each predicted branch into an in-order in-flight queue. When EX
// resolves the oldest branch, the entry is popped and compared against the
// actual outcome. The block produces the predictor history update and, on a
// wrong prediction, a mispredict pulse, the redirect PC and a flush window
// during which wrong-path queue entries and resolutions are discarded.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   pred_valid/state/pc/target  push request from fetch
//   pred_ready                push accepted this cycle
//   ex_valid/taken/target     resolution of the oldest branch from EX
//   hist_valid, history       {actual taken, predicted taken} update pulse
//   mispredict, redirect_pc   wrong-prediction pulse and correct fetch PC
//   flush                     kill wrong-path instructions in IF/ID
//   occupancy                 number of valid queue entries
//   err_underflow             sticky: resolution arrived with queue empty
//   resolved_cnt, mispred_cnt statistics counters (BR_STATS_EN), else 0
//
// Optional feature: define BR_STATS_EN to build the statistics counters.
module branch_resolver #(
  parameter int DEPTH     = 4,
  parameter int PTR_W     = 2,
  parameter int FLUSH_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid,
  input  logic [1:0]       pred_state,
  input  logic [31:0]      pred_pc,
  input  logic [31:0]      pred_target,
  output logic             pred_ready,
  input  logic             ex_valid,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  output logic             hist_valid,
  output logic [1:0]       history,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic [PTR_W:0]   occupancy,
  output logic             err_underflow,
  output logic [31:0]      resolved_cnt,
  output logic [31:0]      mispred_cnt
);

  localparam int CNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [PTR_W:0]   FULL     = (PTR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYC - 1);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t state, state_next;
  logic [CNT_W-1:0] cnt;

  logic [1:0]  q_state  [DEPTH];
  logic [31:0] q_pc     [DEPTH];
  logic [31:0] q_target [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;

  logic [1:0]  head_state;
  logic [31:0] head_pc, head_target;
  logic        resolve, mis_next, push, underflow;

  // The predictor-state LSB travels with the entry but resolution only needs
  // the predicted direction.
  logic unused_state_lsb;
  assign unused_state_lsb = head_state[0];

  always_comb begin
    head_state  = q_state[rd_ptr];
    head_pc     = q_pc[rd_ptr];
    head_target = q_target[rd_ptr];
    resolve     = ex_valid && (state == IDLE) && (occupancy != '0);
    underflow   = ex_valid && (state == IDLE) && (occupancy == '0);
    mis_next    = resolve && ((ex_taken != head_state[1]) ||
                              (ex_taken && (ex_target != head_target)));
    // A mispredicting resolution clears the queue on this edge, so any push
    // in the same cycle must be refused.
    pred_ready  = (occupancy != FULL) && (state == IDLE) && !mis_next;
    push        = pred_valid && pred_ready;
  end

  // FSM: next state and outputs
  always_comb begin
    state_next = state;
    flush      = 1'b0;
    case (state)
      IDLE:  if (mis_next) state_next = FLUSH;
      FLUSH: begin
        flush = 1'b1;
        if (cnt == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= CNT_LOAD;
    end else begin
      state <= state_next;
      if (state == IDLE) cnt <= CNT_LOAD;
      else if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
    end else if (mis_next) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + 1'b1;
      if (resolve) rd_ptr <= rd_ptr + 1'b1;
      case ({push, resolve})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Entry storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      q_state[wr_ptr]  <= pred_state;
      q_pc[wr_ptr]     <= pred_pc;
      q_target[wr_ptr] <= pred_target;
    end
  end

  // Registered resolution outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_valid    <= 1'b0;
      history       <= '0;
      mispredict    <= 1'b0;
      redirect_pc   <= '0;
      err_underflow <= 1'b0;
    end else begin
      hist_valid <= resolve;
      mispredict <= mis_next;
      if (resolve)   history <= {ex_taken, head_state[1]};
      if (mis_next)  redirect_pc <= ex_taken ? ex_target : head_pc + 32'd4;
      if (underflow) err_underflow <= 1'b1;
    end
  end

`ifdef BR_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resolved_cnt <= '0;
      mispred_cnt  <= '0;
    end else begin
      if (resolve)  resolved_cnt <= resolved_cnt + 32'd1;
      if (mis_next) mispred_cnt  <= mispred_cnt + 32'd1;
    end
  end
`else
  assign resolved_cnt = '0;
  assign mispred_cnt  = '0;
`endif

endmodule
